// File: rtl/mips_int_pkg.sv
// Shared definitions for the vectored interrupt controller of the multicycle MIPS core.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package mips_int_pkg;

    // Controller phases: waiting for work, requesting the core, handler running.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Register map, word-indexed on the 2-bit register port.
    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_INSV = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    // CTRL layout: global enable in bit 0, current source ID starting at bit 8.
    localparam int CTRL_GEN_BIT = 0;
    localparam int CTRL_ID_LSB  = 8;

    // A single source still needs a 1-bit ID.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mips_int_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
// Latency: combinational, zero cycles.
// Backpressure: none; purely a function of the request vector.
// Ports: req (one bit per source), any (at least one bit set), idx (lowest set index, 0 when none).
module mips_int_prio_enc
    import mips_int_pkg::*;
#(
    parameter  int NUM_SRC = 8,
    localparam int ID_W    = id_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/mips_int_ctrl.sv
// Vectored interrupt controller: NUM_SRC rising-edge sources, per-source mask, fixed priority, handler vector for the core.
// Latency: source transition to int_req is 2 cycles (4 with MIPS_INT_SYNC_EN); register reads return 1 cycle after reg_re.
// Backpressure: one source in service at a time; later edges stay pending until int_eoi returns the controller to idle.
// Ports: clk/rst (async active-high); irq_src raw sources; int_req/int_vec/int_id to the control unit, int_ack/int_eoi back;
//        reg_addr/reg_wdata/reg_we/reg_re/reg_rdata form the four-word register port (PENDING, MASK, INSERVICE, CTRL).
// Build option: define MIPS_INT_SYNC_EN to put a 2-flop synchronizer on every irq_src bit ahead of edge detection.
module mips_int_ctrl
    import mips_int_pkg::*;
#(
    parameter  int          NUM_SRC   = 8,
    parameter  logic [31:0] VEC_BASE  = 32'h0000_0180,
    parameter  int          VEC_SHIFT = 4,
    localparam int          ID_W      = id_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               int_req,
    output logic [31:0]        int_vec,
    output logic [ID_W-1:0]    int_id,
    input  logic               int_ack,
    input  logic               int_eoi,
    input  logic [1:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    input  logic               reg_we,
    input  logic               reg_re,
    output logic [31:0]        reg_rdata
);

    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] inservice;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] id_onehot;
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] ack_clr;
    logic               gen;
    logic               enc_any;
    logic [ID_W-1:0]    enc_idx;
    logic [ID_W-1:0]    id;
    logic               ack_fire;
    logic               eoi_fire;
    logic [31:0]        rd_mux;
    state_t             state;

    // Only the low NUM_SRC bits (or bit 0 for CTRL) of a write are meaningful.
    logic               unused_wdata;
    assign unused_wdata = ^reg_wdata;

`ifdef MIPS_INT_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    assign irq_s = irq_src;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
        end else begin
            irq_prev <= irq_s;
        end
    end

    assign edges    = irq_s & ~irq_prev;
    assign active   = pending & mask;
    assign ack_fire = (state == ST_REQ) && int_ack;
    assign eoi_fire = (state == ST_SERVICE) && int_eoi;

    mips_int_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req (active),
        .any (enc_any),
        .idx (enc_idx)
    );

    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_onehot[i] = (id == ID_W'(i));
        end
    end

    assign pend_clr = (reg_we && (reg_addr == ADDR_PEND)) ? reg_wdata[NUM_SRC-1:0] : '0;
    assign ack_clr  = ack_fire ? id_onehot : '0;

    // A fresh edge is OR-ed in last, so it wins over both a software clear and the ack clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr & ~ack_clr) | edges;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            gen  <= 1'b0;
        end else if (reg_we) begin
            if (reg_addr == ADDR_MASK) begin
                mask <= reg_wdata[NUM_SRC-1:0];
            end
            if (reg_addr == ADDR_CTRL) begin
                gen <= reg_wdata[CTRL_GEN_BIT];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inservice <= '0;
        end else if (ack_fire) begin
            inservice <= id_onehot;
        end else if (eoi_fire) begin
            inservice <= '0;
        end
    end

    // Once in REQ the request is held until the ack, whatever software does to mask, GEN or PENDING.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gen && enc_any) begin
                        id    <= enc_idx;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (int_eoi) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // id only changes on IDLE->REQ, so ID and vector stay stable through service and show the last value while idle.
    assign int_req = (state == ST_REQ);
    assign int_id  = id;
    assign int_vec = VEC_BASE + (32'(id) << VEC_SHIFT);

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_PEND: rd_mux[NUM_SRC-1:0] = pending;
            ADDR_MASK: rd_mux[NUM_SRC-1:0] = mask;
            ADDR_INSV: rd_mux[NUM_SRC-1:0] = inservice;
            default: begin
                rd_mux[CTRL_GEN_BIT]          = gen;
                rd_mux[CTRL_ID_LSB +: ID_W]   = id;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_rdata <= '0;
        end else if (reg_re) begin
            reg_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Self-checking bench for mips_int_ctrl: directed scenarios plus a randomized run against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mips_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        int_req;
    logic [31:0] int_vec;
    logic [2:0]  int_id;
    logic        int_ack;
    logic        int_eoi;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_int_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .int_id    (int_id),
        .int_ack   (int_ack),
        .int_eoi   (int_eoi),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata)
    );

    // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = handler running.
    bit [7:0]    m_pend, m_mask, m_insv, m_prev;
    bit          m_gen;
    int          m_phase;
    int          m_id;
    logic [31:0] m_rdata;

    function automatic void model_reset();
        m_pend = 0; m_mask = 0; m_insv = 0; m_prev = 0;
        m_gen = 0; m_phase = 0; m_id = 0; m_rdata = 0;
    endfunction

    function automatic void model_update();
        bit [7:0] np;
        int lowest;
        if (rst) begin
            model_reset();
            return;
        end
        if (reg_re) begin
            case (reg_addr)
                2'd0: m_rdata = 32'(m_pend);
                2'd1: m_rdata = 32'(m_mask);
                2'd2: m_rdata = 32'(m_insv);
                default: m_rdata = 32'(m_id * 256 + int'(m_gen));
            endcase
        end
        np = m_pend;
        for (int i = 0; i < 8; i++) begin
            if (reg_we && reg_addr == 2'd0 && reg_wdata[i]) np[i] = 0;
            if (m_phase == 1 && int_ack && m_id == i) np[i] = 0;
            if (irq_src[i] && !m_prev[i]) np[i] = 1;
        end
        lowest = -1;
        for (int i = 7; i >= 0; i--) begin
            if (m_pend[i] && m_mask[i]) lowest = i;
        end
        if (m_phase == 0) begin
            if (m_gen && lowest >= 0) begin
                m_id = lowest;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (int_ack) begin
                m_insv = 0;
                m_insv[m_id] = 1;
                m_phase = 2;
            end
        end else if (int_eoi) begin
            m_insv = 0;
            m_phase = 0;
        end
        if (reg_we && reg_addr == 2'd1) m_mask = reg_wdata[7:0];
        if (reg_we && reg_addr == 2'd3) m_gen = reg_wdata[0];
        m_pend = np;
        m_prev = irq_src;
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        step();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        reg_re = 1'b1; reg_addr = a;
        step();
        reg_re = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq_src = m;
        step();
        irq_src = 8'h00;
        step();
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic do_eoi();
        int_eoi = 1'b1;
        step();
        int_eoi = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; irq_src = 0; int_ack = 0; int_eoi = 0;
        reg_we = 0; reg_re = 0; reg_addr = 0; reg_wdata = 0;
        model_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", int_req); end
        total++; if (int_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", int_id); end
        total++; if (int_vec !== 32'h0000_0180) begin bad++; $display("FAIL reset_vec got=%h want=00000180", int_vec); end
        total++; if (reg_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h want=0", reg_rdata); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            total++; if (reg_rdata !== 32'd0) begin bad++; $display("FAIL reset_reg%0d got=%h want=0", a, reg_rdata); end
        end
    endtask

    task automatic test_basic();
        do_reset();
        wr(2'd1, 32'h04);
        wr(2'd3, 32'h01);
        irq_src = 8'h04;
        step();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_req_early got=%0b want=0", int_req); end
        irq_src = 8'h00;
        step();
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL basic_req got=%0b want=1", int_req); end
        total++; if (int_id !== 3'd2) begin bad++; $display("FAIL basic_id got=%0d want=2", int_id); end
        total++; if (int_vec !== 32'h0000_01A0) begin bad++; $display("FAIL basic_vec got=%h want=000001a0", int_vec); end
        do_ack();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_req_after_ack got=%0b want=0", int_req); end
        rd(2'd2);
        total++; if (reg_rdata !== 32'h04) begin bad++; $display("FAIL basic_insv got=%h want=04", reg_rdata); end
        rd(2'd0);
        total++; if (reg_rdata !== 32'h00) begin bad++; $display("FAIL basic_pend got=%h want=0", reg_rdata); end
        do_eoi();
        rd(2'd2);
        total++; if (reg_rdata !== 32'h00) begin bad++; $display("FAIL basic_insv_eoi got=%h want=0", reg_rdata); end
        total++; if (int_vec !== 32'h0000_01A0) begin bad++; $display("FAIL basic_vec_hold got=%h want=000001a0", int_vec); end
        rd(2'd3);
        total++; if (reg_rdata !== 32'h0000_0201) begin bad++; $display("FAIL basic_ctrl got=%h want=00000201", reg_rdata); end
    endtask

    task automatic test_priority();
        do_reset();
        wr(2'd1, 32'hFF);
        wr(2'd3, 32'h01);
        pulse_irq(8'h22);
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL prio_req1 got=%0b want=1", int_req); end
        total++; if (int_id !== 3'd1) begin bad++; $display("FAIL prio_id1 got=%0d want=1", int_id); end
        do_ack();
        do_eoi();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL prio_idle got=%0b want=0", int_req); end
        step();
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL prio_req2 got=%0b want=1", int_req); end
        total++; if (int_id !== 3'd5) begin bad++; $display("FAIL prio_id2 got=%0d want=5", int_id); end
        total++; if (int_vec !== 32'h0000_01D0) begin bad++; $display("FAIL prio_vec2 got=%h want=000001d0", int_vec); end
    endtask

    task automatic test_mask_clear();
        do_reset();
        wr(2'd3, 32'h01);
        pulse_irq(8'h08);
        step();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL mask_req got=%0b want=0", int_req); end
        rd(2'd0);
        total++; if (reg_rdata !== 32'h08) begin bad++; $display("FAIL mask_pend got=%h want=08", reg_rdata); end
        wr(2'd0, 32'h08);
        rd(2'd0);
        total++; if (reg_rdata !== 32'h00) begin bad++; $display("FAIL mask_pend_clr got=%h want=0", reg_rdata); end
        wr(2'd1, 32'hFF);
        step();
        step();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL mask_unmask_req got=%0b want=0", int_req); end
    endtask

    task automatic test_set_wins();
        do_reset();
        pulse_irq(8'h01);
        irq_src = 8'h01; reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 32'h01;
        step();
        reg_we = 1'b0; irq_src = 8'h00;
        rd(2'd0);
        total++; if (reg_rdata[0] !== 1'b1) begin bad++; $display("FAIL setwins_pend got=%0b want=1", reg_rdata[0]); end
        wr(2'd1, 32'h01);
        wr(2'd3, 32'h01);
        step();
        total++; if (int_req !== 1'b1 || int_id !== 3'd0) begin bad++; $display("FAIL setwins_req got=%0b/%0d want=1/0", int_req, int_id); end
        int_ack = 1'b1; irq_src = 8'h01;
        step();
        int_ack = 1'b0; irq_src = 8'h00;
        rd(2'd0);
        total++; if (reg_rdata !== 32'h01) begin bad++; $display("FAIL ackedge_pend got=%h want=01", reg_rdata); end
        rd(2'd2);
        total++; if (reg_rdata !== 32'h01) begin bad++; $display("FAIL ackedge_insv got=%h want=01", reg_rdata); end
    endtask

    task automatic test_no_retract();
        do_reset();
        wr(2'd1, 32'h04);
        wr(2'd3, 32'h01);
        pulse_irq(8'h04);
        wr(2'd1, 32'h00);
        wr(2'd3, 32'h00);
        wr(2'd0, 32'h04);
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL noretract_req got=%0b want=1", int_req); end
        do_ack();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL noretract_ack got=%0b want=0", int_req); end
        rd(2'd2);
        total++; if (reg_rdata !== 32'h04) begin bad++; $display("FAIL noretract_insv got=%h want=04", reg_rdata); end
    endtask

    task automatic test_ignored();
        do_reset();
        wr(2'd1, 32'h01);
        wr(2'd3, 32'h01);
        do_ack();
        do_eoi();
        rd(2'd2);
        total++; if (reg_rdata !== 32'h00) begin bad++; $display("FAIL ignored_ack_idle got=%h want=0", reg_rdata); end
        pulse_irq(8'h01);
        do_eoi();
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL ignored_eoi_req got=%0b want=1", int_req); end
        do_ack();
        rd(2'd2);
        total++; if (reg_rdata !== 32'h01) begin bad++; $display("FAIL ignored_insv got=%h want=01", reg_rdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(2'd1, 32'h04);
        wr(2'd3, 32'h01);
        pulse_irq(8'h04);
        do_ack();
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%0b want=0", int_req); end
        total++; if (int_vec !== 32'h0000_0180) begin bad++; $display("FAIL rstmid_vec got=%h want=00000180", int_vec); end
        step();
        rst = 1'b0;
        rd(2'd2);
        total++; if (reg_rdata !== 32'h00) begin bad++; $display("FAIL rstmid_insv got=%h want=0", reg_rdata); end
        rd(2'd1);
        total++; if (reg_rdata !== 32'h00) begin bad++; $display("FAIL rstmid_mask got=%h want=0", reg_rdata); end
        rd(2'd3);
        total++; if (reg_rdata !== 32'h00) begin bad++; $display("FAIL rstmid_ctrl got=%h want=0", reg_rdata); end
    endtask

    task automatic test_random();
        do_reset();
        wr(2'd3, 32'h01);
        wr(2'd1, 32'($urandom_range(255)));
        for (int c = 0; c < 800; c++) begin
            irq_src   = irq_src ^ 8'($urandom & $urandom);
            int_ack   = ($urandom_range(2) == 0);
            int_eoi   = ($urandom_range(3) == 0);
            reg_we    = ($urandom_range(9) == 0);
            reg_re    = ($urandom_range(1) == 0);
            reg_addr  = 2'($urandom_range(3));
            reg_wdata = $urandom;
            if (reg_we && reg_addr == 2'd3 && $urandom_range(3) != 0) reg_wdata[0] = 1'b1;
            step();
            total++; if (int_req !== (m_phase == 1)) begin bad++; $display("FAIL rand_req c=%0d got=%0b want=%0b", c, int_req, m_phase == 1); end
            total++; if (int_id !== 3'(m_id)) begin bad++; $display("FAIL rand_id c=%0d got=%0d want=%0d", c, int_id, m_id); end
            total++; if (int_vec !== 32'(32'h180 + m_id * 16)) begin bad++; $display("FAIL rand_vec c=%0d got=%h want=%h", c, int_vec, 32'h180 + m_id * 16); end
            total++; if (reg_rdata !== m_rdata) begin bad++; $display("FAIL rand_rdata c=%0d got=%h want=%h", c, reg_rdata, m_rdata); end
        end
        int_ack = 0; int_eoi = 0; reg_we = 0; reg_re = 0; irq_src = 0;
    endtask

    initial begin
        rst = 1'b1; irq_src = 0; int_ack = 0; int_eoi = 0;
        reg_we = 0; reg_re = 0; reg_addr = 0; reg_wdata = 0;
        model_reset();
        test_reset();
        test_basic();
        test_priority();
        test_mask_clear();
        test_set_wins();
        test_no_retract();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_int_ctrl.md
# mips_int_ctrl

Parametrised vectored interrupt controller for the multicycle MIPS core. It replaces the single `int0` line that feeds the control unit with `NUM_SRC` edge-triggered sources, per-source masking, fixed priority and a vector address the control unit loads into the PC. It sits between the peripherals (UART, LEDs, timers) and the control unit. Software configures it through a four-word register port.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..32.
- `VEC_BASE`, 32'h0000_0180: handler table base address.
- `VEC_SHIFT`, 4: log2 of the byte stride between handler entries.
- `ID_W`, derived as max(1, clog2(NUM_SRC)): width of the source ID.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `irq_src` in NUM_SRC: raw interrupt sources; a rising edge requests service.
- `int_req` out 1: interrupt request to the control unit.
- `int_vec` out 32: handler address, VEC_BASE + (id << VEC_SHIFT).
- `int_id` out ID_W: ID of the requested or in-service source.
- `int_ack` in 1: single-cycle pulse from the control unit once the PC has been saved.
- `int_eoi` in 1: single-cycle end-of-interrupt pulse, issued on return from the handler.
- `reg_addr` in 2: register select.
- `reg_wdata` in 32: write data.
- `reg_we` in 1: register write strobe.
- `reg_re` in 1: register read strobe.
- `reg_rdata` out 32: read data.

## Operation
- **Edge detection:** `irq_prev` holds `irq_src` delayed by one cycle. A source edge is `irq_src & ~irq_prev`.
- **Registers:**
  - 0 PENDING: read; writing 1 clears the bit.
  - 1 MASK: read/write; 1 enables the source.
  - 2 INSERVICE: read-only one-hot.
  - 3 CTRL: bit0 GEN (global enable, read/write); bits [8+ID_W-1:8] hold the current `int_id` (read-only).
- **Register width:** bits at and above NUM_SRC read as 0 and are not writable.
- **State machine:**
  - IDLE: when GEN is set and (PENDING & MASK) is non-zero, latch the lowest set index into `id` and move to REQ.
  - REQ: `int_req` = 1. On `int_ack`, clear PENDING[id], set INSERVICE[id] and move to SERVICE.
  - SERVICE: `int_req` = 0. On `int_eoi`, clear INSERVICE and return to IDLE.
- **No nesting:** only one source is in service at a time. New edges that arrive during REQ or SERVICE stay pending.
- **Request is never retracted:** once in REQ, clearing the mask bit, clearing GEN or clearing the pending bit does not drop `int_req`. The acknowledge then clears PENDING[id], which may already be 0.
- **Ignored strobes:**
  - `int_ack` outside REQ is ignored.
  - `int_eoi` outside SERVICE is ignored.
- **Simultaneous events:**
  - An edge and a write-1 clear on the same bit in the same cycle: the set wins.
  - An edge on the acknowledged source in the ack cycle: PENDING stays 1.
- **Stable outputs:** `int_id` and `int_vec` are held from REQ entry until the return to IDLE. In IDLE they show the last value.

## Timing
- **Reset values:** `int_req` = 0, `int_id` = 0, `int_vec` = VEC_BASE, `reg_rdata` = 0. Internally PENDING = 0, MASK = 0, INSERVICE = 0, GEN = 0, `irq_prev` = 0, state IDLE.
- **Request latency:** a source edge sampled at edge n sets PENDING at n. `int_req` rises at n+1 when the controller is idle and the source is enabled, so there are 2 cycles from the source transition to `int_req`.
- **Register reads:** registered; `reg_rdata` is valid the cycle after `reg_re` and holds until the next read.
- **Register writes:** take effect at the strobe edge. A mask write at edge n is seen by arbitration from n+1.
- **Return to idle:** `int_eoi` at edge n returns the controller to IDLE at n. A pending source can raise `int_req` at n+1.
- **Reset mid-operation:** all state returns to reset values immediately. Any request in flight is lost.

## Configuration
- `MIPS_INT_SYNC_EN` defined: each `irq_src` bit passes through a 2-flop synchronizer ahead of edge detection. Request latency grows by 2 cycles.
- Not defined: `irq_src` is treated as already synchronous to `clk`.

## Structure
- **Package `mips_int_pkg`:** state enum (IDLE, REQ, SERVICE), register address constants (ADDR_PEND, ADDR_MASK, ADDR_INSV, ADDR_CTRL) and the CTRL bit positions.
- **Sub-module `mips_int_prio_enc`:** combinational lowest-index-first encoder, parametrised by NUM_SRC. Outputs `any` and `idx[ID_W-1:0]`.

## Test plan
- **Basic service:** reset, write MASK = 8'h04, GEN = 1, pulse `irq_src[2]`.
  - `int_req` = 1 two cycles later, `int_id` = 2, `int_vec` = 32'h0000_01A0.
  - `int_ack` → INSERVICE = 8'h04 and PENDING = 0.
  - `int_eoi` → state returns to IDLE.
- **Priority:** MASK = 8'hFF, GEN = 1, edges on sources 5 and 1 in the same cycle.
  - Source 1 is served first.
  - After `int_eoi`, `int_req` rises again with `int_id` = 5.
- **Masking and clear:** MASK = 0, edge on source 3.
  - PENDING reads 8'h08 and `int_req` stays 0.
  - Writing 8'h08 to PENDING clears it; a subsequent unmask raises no request.
- **Set wins:** write-1 clear of bit 0 in the same cycle as a source-0 edge → PENDING[0] reads 1.
- **No retraction:** during REQ, clear MASK and GEN → `int_req` stays 1 until `int_ack`.
- **Reset mid-service:** assert `rst` during SERVICE → `int_req` = 0, INSERVICE = 0, MASK = 0 on the next read after reset.
